// File: rtl/ysyx_25040111_mem_arb.sv
// Two-requester arbiter (I-cache refill bursts, D-side single accesses) in front of one LSU port.
// Optional round-robin contention resolution: define YSYX_25040111_ARB_RR_EN.
module ysyx_25040111_mem_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  // I side
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  input  logic [CNT_W-1:0] i_len,
  output logic [31:0]      i_rdata,
  output logic             i_valid,
  output logic             i_done,
  // D side
  input  logic             d_req,
  input  logic             d_wen,
  input  logic             d_ren,
  input  logic             d_sign,
  input  logic [1:0]       d_mask,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic [31:0]      d_rdata,
  output logic             d_done,
  // LSU side
  output logic             m_start,
  output logic             m_wen,
  output logic             m_ren,
  output logic             m_sign,
  output logic [1:0]       m_mask,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  output logic [CNT_W-1:0] m_tlen,
  input  logic [31:0]      m_rdata,
  input  logic             m_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               owner_r;      // 0 = I, 1 = D
  logic [CNT_W-1:0]   cnt_r;
  logic               wen_r;
  logic               ren_r;
  logic               sign_r;
  logic [1:0]         mask_r;
  logic [31:0]        addr_r;
  logic [31:0]        wdata_r;
  logic [CNT_W-1:0]   tlen_r;
  logic               start_r;
  logic               busy_r;

  logic               take_s;
  logic               grant_d_s;
  logic               i_valid_s;
  logic               i_done_s;
  logic               d_done_s;

`ifdef YSYX_25040111_ARB_RR_EN
  logic               last_r;       // side granted most recently: 0 = I, 1 = D

  // Round-robin: under contention grant the side that was not granted last.
  always_comb begin
    grant_d_s = 1'b0;
    if (d_req && (!i_req || !last_r)) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
  end

  // Last-grant history, updated on every grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_r <= 1'b0;
    end else if (take_s) begin
      last_r <= grant_d_s;
    end
  end
`else
  // Fixed priority: D wins whenever it requests.
  always_comb begin
    grant_d_s = 1'b0;
    if (d_req) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
  end
`endif

  // Response strobes are only meaningful in WAIT and only toward the current owner.
  always_comb begin
    i_valid_s = 1'b0;
    i_done_s  = 1'b0;
    d_done_s  = 1'b0;
    if (state_r == WAIT && m_valid) begin
      if (owner_r) begin
        d_done_s = 1'b1;
      end else begin
        i_valid_s = 1'b1;
        i_done_s  = (cnt_r == tlen_r);
      end
    end else begin
      i_valid_s = 1'b0;
      i_done_s  = 1'b0;
      d_done_s  = 1'b0;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    take_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_req || d_req) begin
          state_nxt_s = ISSUE;
          take_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (i_done_s || d_done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register plus start/busy flags registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      start_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      start_r <= (state_nxt_s == ISSUE);
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // Command fields captured at grant; held until the next grant so m_* never moves mid-transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_r <= 1'b0;
      wen_r   <= 1'b0;
      ren_r   <= 1'b0;
      sign_r  <= 1'b0;
      mask_r  <= 2'b00;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      tlen_r  <= {CNT_W{1'b0}};
    end else if (take_s) begin
      if (grant_d_s) begin
        owner_r <= 1'b1;
        wen_r   <= d_wen;
        ren_r   <= d_ren;
        sign_r  <= d_sign;
        mask_r  <= d_mask;
        addr_r  <= d_addr;
        wdata_r <= d_wdata;
        tlen_r  <= {CNT_W{1'b0}};
      end else begin
        owner_r <= 1'b0;
        wen_r   <= 1'b0;
        ren_r   <= 1'b1;
        sign_r  <= 1'b0;
        mask_r  <= 2'b11;
        addr_r  <= i_addr;
        wdata_r <= 32'h0000_0000;
        tlen_r  <= i_len;
      end
    end
  end

  // Beat counter: cleared on entering ISSUE, advanced on every I beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_nxt_s == ISSUE) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (i_valid_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign m_start = start_r;
  assign busy    = busy_r;
  assign m_wen   = wen_r;
  assign m_ren   = ren_r;
  assign m_sign  = sign_r;
  assign m_mask  = mask_r;
  assign m_addr  = addr_r;
  assign m_wdata = wdata_r;
  assign m_tlen  = tlen_r;

  // Read data is passed through in the strobe cycle and forced to zero otherwise.
  assign i_valid = i_valid_s;
  assign i_done  = i_done_s;
  assign i_rdata = i_valid_s ? m_rdata : 32'h0000_0000;
  assign d_done  = d_done_s;
  assign d_rdata = d_done_s ? m_rdata : 32'h0000_0000;

endmodule

// File: doc/ysyx_25040111_mem_arb.md
YSYX_25040111_MEM_ARB -- requirements
Module: ysyx_25040111_mem_arb

Interface
REQ-001 SHALL have parameter CNT_W, default 8, beat counter width; equal to LSU tlen width.
REQ-002 SHALL have port clock  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have I-side ports: i_req in 1 refill request; i_addr in 32 burst base address; i_len in CNT_W beats minus one.
REQ-005 SHALL have I-side ports: i_rdata out 32 beat data; i_valid out 1 beat strobe; i_done out 1 last-beat strobe.
REQ-006 SHALL have D-side ports: d_req in 1 request; d_wen in 1 store; d_ren in 1 load; d_sign in 1 sign-extend; d_mask in 2 size.
REQ-007 SHALL have D-side ports: d_addr in 32; d_wdata in 32; d_rdata out 32; d_done out 1 completion strobe.
REQ-008 SHALL have LSU-side ports: m_start out 1; m_wen out 1; m_ren out 1; m_sign out 1; m_mask out 2; m_addr out 32; m_wdata out 32; m_tlen out CNT_W.
REQ-009 SHALL have LSU-side inputs: m_rdata in 32 beat data; m_valid in 1 beat/completion strobe.
REQ-010 SHALL have observability output busy out 1, high in any state other than IDLE.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT; registered owner bit (0 = I, 1 = D).
REQ-012 IDLE: if any request is high at the edge, SHALL latch owner and request fields, go to ISSUE; otherwise stay.
REQ-013 Both requests high in IDLE: SHALL grant D (fixed priority) unless the Configuration feature is enabled.
REQ-014 ISSUE: SHALL drive m_start=1 for exactly one cycle, then go to WAIT.
REQ-015 m_* command outputs SHALL come from latched fields and stay stable from ISSUE until return to IDLE; requester input changes after grant are ignored.
REQ-016 I grant: m_ren=1, m_wen=0, m_mask=2'b11, m_sign=0, m_tlen=latched i_len, m_addr=latched i_addr.
REQ-017 D grant: m_wen/m_ren/m_sign/m_mask/m_addr/m_wdata = latched D fields, m_tlen=0.
REQ-018 WAIT, owner I: each m_valid SHALL produce i_valid=1 with i_rdata=m_rdata the same cycle (combinational pass-through) and increment beat counter.
REQ-019 Owner I: the beat where counter equals latched i_len SHALL also assert i_done and go to IDLE; i_len=0 means single beat.
REQ-020 WAIT, owner D: first m_valid SHALL assert d_done with d_rdata=m_rdata that cycle and go to IDLE.
REQ-021 i_valid/i_done SHALL be 0 when owner is D; d_done SHALL be 0 when owner is I; outside WAIT all strobes 0.
REQ-022 m_valid in IDLE or ISSUE SHALL be ignored.
REQ-023 At least one IDLE cycle SHALL separate consecutive transactions; grant-to-m_start latency exactly one cycle.
REQ-024 Beat counter SHALL be CNT_W bits, cleared on entering ISSUE; no wrap possible since i_len <= 2^CNT_W-1.
REQ-025 Request with d_wen=d_ren=0 SHALL still be granted and complete on m_valid (LSU pass-through).

Reset
REQ-026 reset SHALL force IDLE, owner=0, counter=0, last-grant=I, all latched fields 0, in the same edge, including mid-transaction.
REQ-027 During and after reset, all outputs SHALL be 0 until a new grant; no done strobe for an aborted transaction.

Configuration
REQ-028 Macro YSYX_25040111_ARB_RR_EN defined: contention SHALL be resolved round-robin (grant side not last granted; last-grant updated on every grant).
REQ-029 Macro undefined: fixed D priority; no last-grant register instantiated.

Verification
REQ-030 Single I burst: i_req, i_addr=0x3000_0000, i_len=3, m_valid on 4 cycles -> m_start one cycle after grant, m_tlen=3, four i_valid, i_done on 4th only, busy drops next cycle.
REQ-031 D load: d_req, d_ren=1, d_mask=2'b01, d_sign=1, addr=0x8000_0010; m_valid with m_rdata=0xFFFF_FF80 -> d_done with d_rdata=0xFFFF_FF80, m_tlen=0, no i_valid.
REQ-032 Simultaneous i_req and d_req, both held -> default: D first, then I; with YSYX_25040111_ARB_RR_EN and last-grant=I: D then I; repeat pair -> alternates.
REQ-033 i_addr changed to 0x0 during WAIT -> m_addr holds original 0x3000_0000 until i_done.
REQ-034 reset asserted after 2 of 4 I beats -> next cycle IDLE, busy=0, no i_done; new d_req served normally.
REQ-035 Stray m_valid while IDLE -> no i_valid, i_done or d_done.
